// File: rtl/nvdla_glb_csb_pkg.sv
// Shared definitions for the CSB-to-GLB retiming/ordering stage.
// Holds payload widths, field positions inside the request and response
// words, the response payload struct and a helper that tells whether a
// request expects a response from GLB.
package nvdla_glb_csb_pkg;

  localparam int CSB_REQ_W     = 63;
  localparam int CSB_RESP_W    = 34;

  localparam int ADDR_LSB      = 0;
  localparam int ADDR_MSB      = 21;
  localparam int WRITE_BIT     = 54;
  localparam int NPOSTED_BIT   = 55;

  localparam int RESP_ERR_BIT  = 32;
  localparam int RESP_TYPE_BIT = 33;

  // Response word as seen on both the GLB side and the upstream side.
  typedef struct packed {
    logic        rtype;
    logic        error;
    logic [31:0] rdat;
  } csb_resp_t;

  // Reads and non-posted writes expect an answer; posted writes do not.
  function automatic logic needs_resp(input logic [CSB_REQ_W-1:0] pd);
    return !pd[WRITE_BIT] || pd[NPOSTED_BIT];
  endfunction

endpackage

// File: rtl/nvdla_glb_csb_type_fifo.sv
// Expected-response-type FIFO for the CSB pipe.
// Records the write bit of every response-needing request handed to GLB so
// each GLB response can be checked against the type it should carry.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   push        store push_type (ignored when full unless popping too)
//   push_type   0 = read, 1 = non-posted write
//   pop         drop the head entry (ignored when empty)
//   head_type   type at the head of the FIFO
//   empty/full  occupancy flags
//   count       current occupancy (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module nvdla_glb_csb_type_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   push_type,
  input  logic                   pop,
  output logic                   head_type,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign head_type = mem[rd_ptr];

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_type;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/nvdla_glb_csb_pipe.sv
// CSB retiming and ordering stage in front of the GLB register block.
// Requests pass through a 2-entry skid buffer; responses get one register
// stage. Response-needing requests are tracked in a type FIFO and new ones
// stall once MAX_OUTST are in flight or queued.
// Optional feature macro: NVDLA_GLB_CSB_TIMEOUT_EN adds a watchdog that
// answers unanswered requests with an error response and discards the
// matching late GLB responses afterwards.
// Ports:
//   nvdla_core_clk / nvdla_core_rst   clock, synchronous active-high reset
//   csb_req_pvld/prdy/pd              upstream request handshake + 63b payload
//   csb2glb_req_pvld/prdy/pd          request handshake towards GLB
//   glb2csb_resp_valid/pd             GLB response strobe + 34b payload
//   csb_resp_valid/pd                 registered response towards upstream
//   stray_resp                        sticky flag: response with nothing pending
module nvdla_glb_csb_pipe
  import nvdla_glb_csb_pkg::*;
#(
  parameter int MAX_OUTST   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  csb_req_pvld,
  output logic                  csb_req_prdy,
  input  logic [CSB_REQ_W-1:0]  csb_req_pd,
  output logic                  csb2glb_req_pvld,
  input  logic                  csb2glb_req_prdy,
  output logic [CSB_REQ_W-1:0]  csb2glb_req_pd,
  input  logic                  glb2csb_resp_valid,
  input  logic [CSB_RESP_W-1:0] glb2csb_resp_pd,
  output logic                  csb_resp_valid,
  output logic [CSB_RESP_W-1:0] csb_resp_pd,
  output logic                  stray_resp
);

  localparam int CW = $clog2(MAX_OUTST);

  if (MAX_OUTST < 2 || (MAX_OUTST & (MAX_OUTST - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_bad_params
    $error("nvdla_glb_csb_pipe: MAX_OUTST must be a power of two >= 2 and TIMEOUT_CYC >= 2");
  end

  logic [CSB_REQ_W-1:0]  slot0_pd;
  logic [CSB_REQ_W-1:0]  slot1_pd;
  logic                  slot0_vld;
  logic                  slot1_vld;
  logic                  accept;
  logic                  deq;
  logic                  stall;
  logic [CW+1:0]         pending;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_head;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CW:0]           outst_cnt;

  logic                  resp_vld_d;
  logic [CSB_RESP_W-1:0] resp_pd_d;
  logic                  stray_set;

  // Responses we are committed to: already at GLB plus response-needing
  // requests still sitting in the skid buffer.
  assign pending = (CW+2)'(outst_cnt)
                 + (CW+2)'(slot0_vld && needs_resp(slot0_pd))
                 + (CW+2)'(slot1_vld && needs_resp(slot1_pd));

  assign stall = needs_resp(csb_req_pd) &&
                 (fifo_full || (pending >= (CW+2)'(MAX_OUTST)));

  // Held low during reset so every output reads 0 while reset is asserted.
  assign csb_req_prdy     = !nvdla_core_rst && !slot1_vld && !stall;
  assign accept           = csb_req_pvld && csb_req_prdy;
  assign deq              = slot0_vld && csb2glb_req_prdy;
  assign csb2glb_req_pvld = slot0_vld;
  assign csb2glb_req_pd   = slot0_pd;
  assign fifo_push        = deq && needs_resp(slot0_pd);

  // slot0 drives GLB; slot1 only fills when GLB stalls while a new beat
  // is being accepted. accept implies slot1 is empty.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      slot0_vld <= 1'b0;
      slot1_vld <= 1'b0;
      slot0_pd  <= '0;
      slot1_pd  <= '0;
    end else if (deq) begin
      if (slot1_vld) begin
        slot0_pd  <= slot1_pd;
        slot1_vld <= 1'b0;
      end else if (accept) begin
        slot0_pd  <= csb_req_pd;
      end else begin
        slot0_vld <= 1'b0;
      end
    end else if (accept) begin
      if (!slot0_vld) begin
        slot0_pd  <= csb_req_pd;
        slot0_vld <= 1'b1;
      end else begin
        slot1_pd  <= csb_req_pd;
        slot1_vld <= 1'b1;
      end
    end
  end

  nvdla_glb_csb_type_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_type_fifo (
    .clk       (nvdla_core_clk),
    .rst       (nvdla_core_rst),
    .push      (fifo_push),
    .push_type (slot0_pd[WRITE_BIT]),
    .pop       (fifo_pop),
    .head_type (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (outst_cnt)
  );

`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

  logic [WD_W-1:0] wd_cnt;
  logic [CW:0]     drop_cnt;
  logic            drop_inc;
  logic            drop_dec;
  logic            wd_fire;
  csb_resp_t       timeout_pd;

  // The handshake cycle counts as the first cycle outstanding.
  assign wd_fire    = !fifo_empty && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign timeout_pd = '{rtype: fifo_head, error: 1'b1, rdat: 32'h0};
`endif

  // Response decision: drop answers owed to timed-out requests, flag
  // answers with nothing pending, otherwise pop and forward with the error
  // bit forced on a type mismatch. A GLB response always beats a timeout.
  always_comb begin
    resp_vld_d = 1'b0;
    resp_pd_d  = glb2csb_resp_pd;
    fifo_pop   = 1'b0;
    stray_set  = 1'b0;
`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
    drop_inc   = 1'b0;
    drop_dec   = 1'b0;
`endif
    if (glb2csb_resp_valid) begin
`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
      if (drop_cnt != '0) begin
        drop_dec = 1'b1;
      end else
`endif
      if (fifo_empty) begin
        stray_set = 1'b1;
      end else begin
        fifo_pop   = 1'b1;
        resp_vld_d = 1'b1;
        if (glb2csb_resp_pd[RESP_TYPE_BIT] != fifo_head) begin
          resp_pd_d[RESP_ERR_BIT] = 1'b1;
        end
      end
    end
`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
    else if (wd_fire) begin
      fifo_pop   = 1'b1;
      resp_vld_d = 1'b1;
      resp_pd_d  = timeout_pd;
      drop_inc   = 1'b1;
    end
`endif
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      csb_resp_valid <= 1'b0;
      csb_resp_pd    <= '0;
      stray_resp     <= 1'b0;
    end else begin
      csb_resp_valid <= resp_vld_d;
      if (resp_vld_d) begin
        csb_resp_pd <= resp_pd_d;
      end
      if (stray_set) begin
        stray_resp <= 1'b1;
      end
    end
  end

`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
  // Watchdog restarts on any pop or GLB response and idles at 0 while empty.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      wd_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (fifo_pop || glb2csb_resp_valid || (fifo_empty && !fifo_push)) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (drop_inc) begin
        drop_cnt <= drop_cnt + 1'b1;
      end else if (drop_dec) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nvdla_glb_csb_pipe.sv
// Directed testbench for nvdla_glb_csb_pipe (MAX_OUTST=4, TIMEOUT_CYC=16).
// Inputs are driven 1ns after the rising edge and outputs sampled 1ns
// after that. The timeout scenario follows NVDLA_GLB_CSB_TIMEOUT_EN.
module tb_nvdla_glb_csb_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqPvld = 1'b0;
  logic        reqPrdy;
  logic [62:0] reqPd = '0;
  logic        glbReqPvld;
  logic        glbReqPrdy = 1'b1;
  logic [62:0] glbReqPd;
  logic        glbRespValid = 1'b0;
  logic [33:0] glbRespPd = '0;
  logic        respValid;
  logic [33:0] respPd;
  logic        strayResp;

  int vectorCnt = 0;
  int missCnt   = 0;

  always #5 clk = ~clk;

  nvdla_glb_csb_pipe #(
    .MAX_OUTST   (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rst     (rst),
    .csb_req_pvld       (reqPvld),
    .csb_req_prdy       (reqPrdy),
    .csb_req_pd         (reqPd),
    .csb2glb_req_pvld   (glbReqPvld),
    .csb2glb_req_prdy   (glbReqPrdy),
    .csb2glb_req_pd     (glbReqPd),
    .glb2csb_resp_valid (glbRespValid),
    .glb2csb_resp_pd    (glbRespPd),
    .csb_resp_valid     (respValid),
    .csb_resp_pd        (respPd),
    .stray_resp         (strayResp)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectorCnt++;
    if (got !== exp) begin
      missCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [62:0] rpd, input logic grdy,
                               input logic gv, input logic [33:0] gpd);
    reqPvld      = rv;
    reqPd        = rpd;
    glbReqPrdy   = grdy;
    glbRespValid = gv;
    glbRespPd    = gpd;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 63'h0, 1'b1, 1'b0, 34'h0);
  endtask

  function automatic logic [62:0] mkReq(input logic wr, input logic np,
                                        input logic [21:0] addr, input logic [31:0] wdat);
    return {5'd0, 1'b0, 1'b0, np, wr, wdat, addr};
  endfunction

  function automatic logic [62:0] rdReq(input int i);
    return mkReq(1'b0, 1'b0, 22'(i * 4), 32'h0);
  endfunction

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_prdy"},      reqPrdy,    0);
    checkOutput({pfx, "_glb_pvld"},  glbReqPvld, 0);
    checkOutput({pfx, "_glb_pd"},    glbReqPd,   0);
    checkOutput({pfx, "_resp_vld"},  respValid,  0);
    checkOutput({pfx, "_resp_pd"},   respPd,     0);
    checkOutput({pfx, "_stray"},     strayResp,  0);
  endtask

  // Full read round trip: accept, hand to GLB, answer, check forwarded response.
  task automatic doRead(input string tag, input logic [21:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, mkReq(1'b0, 1'b0, addr, 32'h0), 1'b1, 1'b0, 34'h0);
    step();
    idle();
    checkOutput({tag, "_issue"}, glbReqPvld, 1);
    step();
    applyStimulus(1'b0, 63'h0, 1'b1, 1'b1, {2'b00, data});
    step();
    idle();
    checkOutput({tag, "_vld"}, respValid, 1);
    checkOutput({tag, "_pd"},  respPd,    {2'b00, data});
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [62:0] wq [8];
  logic [33:0] rsp [4];
  logic [33:0] rspExp [4];
  logic [62:0] pw;
  int inIdx;
  int outIdx;
  int sawResp;
  int lat;

  initial begin
    // Reset state.
    idle();
    rst = 1'b1;
    step();
    step();
    checkResetOutputs("rst");
    rst = 1'b0;
    step();

    // 1: single read, 1-cycle request latency, 1-cycle response latency.
    applyStimulus(1'b1, rdReq(1), 1'b1, 1'b0, 34'h0);
    checkOutput("t1_prdy", reqPrdy, 1);
    checkOutput("t1_pvld_T", glbReqPvld, 0);
    step();
    idle();
    checkOutput("t1_pvld_T1", glbReqPvld, 1);
    checkOutput("t1_pd_T1", glbReqPd, rdReq(1));
    step();
    checkOutput("t1_pvld_T2", glbReqPvld, 0);
    step();
    step();
    applyStimulus(1'b0, 63'h0, 1'b1, 1'b1, {2'b00, 32'hDEADBEEF});
    checkOutput("t1_resp_T5", respValid, 0);
    step();
    idle();
    checkOutput("t1_resp_T6", respValid, 1);
    checkOutput("t1_resp_pd", respPd, {2'b00, 32'hDEADBEEF});
    step();
    checkOutput("t1_resp_T7", respValid, 0);

    // 2: eight posted writes, GLB not ready for the first three cycles.
    for (int i = 0; i < 8; i++) wq[i] = mkReq(1'b1, 1'b0, 22'(32'h100 + i * 4), 32'hA000_0000 + i);
    inIdx = 0;
    outIdx = 0;
    sawResp = 0;
    for (int c = 0; c < 30 && outIdx < 8; c++) begin
      applyStimulus(inIdx < 8, (inIdx < 8) ? wq[inIdx] : 63'h0, c >= 3, 1'b0, 34'h0);
      if (c == 1) checkOutput("t2_prdy_c1", reqPrdy, 1);
      if (c == 2) begin
        checkOutput("t2_prdy_drop", reqPrdy, 0);
        checkOutput("t2_accepted", inIdx, 2);
      end
      if (glbReqPvld && glbReqPrdy) begin
        checkOutput($sformatf("t2_beat%0d", outIdx), glbReqPd, wq[outIdx]);
        outIdx++;
      end
      if (respValid) sawResp++;
      if (reqPvld && reqPrdy) inIdx++;
      step();
    end
    idle();
    for (int c = 0; c < 3; c++) begin
      if (respValid) sawResp++;
      step();
    end
    checkOutput("t2_all_out", outIdx, 8);
    checkOutput("t2_no_resp", sawResp, 0);

    // 3: four reads fill the window, fifth stalls, posted write waits behind it.
    inIdx = 0;
    for (int c = 0; c < 20 && inIdx < 4; c++) begin
      applyStimulus(1'b1, rdReq(inIdx), 1'b1, 1'b0, 34'h0);
      if (reqPrdy) inIdx++;
      step();
    end
    checkOutput("t3_four_issued", inIdx, 4);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, rdReq(4), 1'b1, 1'b0, 34'h0);
      checkOutput($sformatf("t3_stall%0d", c), reqPrdy, 0);
      step();
    end
    checkOutput("t3_stall_no_pvld", glbReqPvld, 0);
    applyStimulus(1'b1, rdReq(4), 1'b1, 1'b1, {2'b00, 32'h1111_0000});
    checkOutput("t3_stall_resp_cycle", reqPrdy, 0);
    step();
    applyStimulus(1'b1, rdReq(4), 1'b1, 1'b0, 34'h0);
    checkOutput("t3_release", reqPrdy, 1);
    checkOutput("t3_resp_vld", respValid, 1);
    checkOutput("t3_resp_pd", respPd, {2'b00, 32'h1111_0000});
    step();
    pw = mkReq(1'b1, 1'b0, 22'h200, 32'hCAFE_F00D);
    applyStimulus(1'b1, pw, 1'b1, 1'b0, 34'h0);
    checkOutput("t3_pw_prdy", reqPrdy, 1);
    checkOutput("t3_order_r4", glbReqPd, rdReq(4));
    step();
    idle();
    checkOutput("t3_order_pw_vld", glbReqPvld, 1);
    checkOutput("t3_order_pw", glbReqPd, pw);
    step();
    // Remaining four: a wrong-type answer gets its error bit forced,
    // a GLB-reported error passes through unchanged.
    rsp[0] = {1'b1, 1'b0, 32'hAAAA_0001};  rspExp[0] = {1'b1, 1'b1, 32'hAAAA_0001};
    rsp[1] = {1'b0, 1'b0, 32'hAAAA_0002};  rspExp[1] = {1'b0, 1'b0, 32'hAAAA_0002};
    rsp[2] = {1'b0, 1'b1, 32'hAAAA_0003};  rspExp[2] = {1'b0, 1'b1, 32'hAAAA_0003};
    rsp[3] = {1'b0, 1'b0, 32'hAAAA_0004};  rspExp[3] = {1'b0, 1'b0, 32'hAAAA_0004};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 63'h0, 1'b1, 1'b1, rsp[i]);
      step();
      checkOutput($sformatf("t3_drain%0d_vld", i), respValid, 1);
      checkOutput($sformatf("t3_drain%0d_pd", i), respPd, rspExp[i]);
    end
    idle();
    step();
    checkOutput("t3_drained", respValid, 0);
    checkOutput("t3_no_stray", strayResp, 0);

    // 4: response with nothing outstanding.
    applyStimulus(1'b0, 63'h0, 1'b1, 1'b1, {2'b00, 32'h0000_5555});
    step();
    idle();
    checkOutput("t4_no_resp", respValid, 0);
    checkOutput("t4_stray", strayResp, 1);
    for (int c = 0; c < 5; c++) step();
    checkOutput("t4_stray_held", strayResp, 1);

    // 5: unanswered read.
    doReset();
    checkOutput("t5_stray_cleared", strayResp, 0);
    applyStimulus(1'b1, rdReq(7), 1'b1, 1'b0, 34'h0);
    step();
    idle();
    checkOutput("t5_issue", glbReqPvld, 1);
`ifdef NVDLA_GLB_CSB_TIMEOUT_EN
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (respValid) begin
        lat = c;
        break;
      end
    end
    checkOutput("t5_timeout_lat", lat, 16);
    checkOutput("t5_timeout_pd", respPd, {1'b0, 1'b1, 32'h0});
    step();
    applyStimulus(1'b0, 63'h0, 1'b1, 1'b1, {2'b00, 32'h0000_0BAD});
    step();
    idle();
    checkOutput("t5_late_dropped", respValid, 0);
    checkOutput("t5_late_no_stray", strayResp, 0);
`else
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (respValid) lat++;
    end
    checkOutput("t5_no_watchdog", lat, 0);
    applyStimulus(1'b0, 63'h0, 1'b1, 1'b1, {2'b00, 32'h0000_0BAD});
    step();
    idle();
    checkOutput("t5_late_vld", respValid, 1);
    checkOutput("t5_late_pd", respPd, {2'b00, 32'h0000_0BAD});
`endif
    step();
    doRead("t5_followup", 22'h3C, 32'h1234_5678);
    checkOutput("t5_followup_stray", strayResp, 0);

    // 6: reset with two reads outstanding.
    step();
    applyStimulus(1'b1, rdReq(8), 1'b1, 1'b0, 34'h0);
    step();
    applyStimulus(1'b1, rdReq(9), 1'b1, 1'b0, 34'h0);
    step();
    idle();
    step();
    rst = 1'b1;
    step();
    checkResetOutputs("t6");
    rst = 1'b0;
    sawResp = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (respValid) sawResp++;
    end
    checkOutput("t6_no_ghost_resp", sawResp, 0);
    doRead("t6_post_reset", 22'h40, 32'h0BAD_F00D);
    checkOutput("t6_stray", strayResp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCnt, missCnt);
    $finish;
  end

endmodule
